// File: rtl/uart_tx_param.sv
// uart_tx_param: FIFO-buffered UART transmitter. It supports a configurable
// character width, parity and stop length, plus flush and timed break.
// Optional build macro UART_TX_CTS_EN adds cts_n_i flow control on frame start.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | line high; start a queued frame or a requested break
// S_START  | start bit (line low) for one bit time
// S_DATA   | character bits, LSB first
// S_PARITY | parity bit (skipped when parity is disabled)
// S_STOP   | line high for 1, 1.5 or 2 bit times, then tx_done pulse
// S_BREAK  | line low for BREAK_BITS bit times, then break_done pulse
module uart_tx_param #(
    parameter int DATA_MAX_W = 9,
    parameter int FIFO_DEPTH = 16,
    parameter int OVS_RATIO  = 16,
    parameter int BREAK_BITS = 12
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          enable_i,
    input  logic                          ov_baud_rt_i,
    input  logic [DATA_MAX_W-1:0]         data_i,
    input  logic                          write_i,
    input  logic                          flush_i,
    input  logic [3:0]                    data_width_i,
    input  logic [1:0]                    parity_mode_i,
    input  logic [1:0]                    stop_bits_i,
    input  logic                          break_req_i,
`ifdef UART_TX_CTS_EN
    input  logic                          cts_n_i,
`endif
    output logic                          tx_o,
    output logic                          tx_done_o,
    output logic                          break_done_o,
    output logic                          fifo_full_o,
    output logic                          fifo_empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          overflow_o,
    output logic                          idle_o
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int LW   = AW + 1;
    localparam int CW   = $clog2(2 * OVS_RATIO);
    localparam int BMAX = (BREAK_BITS > DATA_MAX_W) ? BREAK_BITS : DATA_MAX_W;
    localparam int BW   = $clog2(BMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_MAX_W-1:0] shift_q, shift_d;
    logic [3:0]            width_q, width_d;
    logic [1:0]            par_mode_q, par_mode_d;
    logic [1:0]            stop_q, stop_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;
    logic                  done_q, done_d;
    logic                  brk_done_q, brk_done_d;

    logic [DATA_MAX_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  ovf_q, ovf_d;

    logic                  full, empty, push, pop, cts_ok, last_tick;
    logic [CW-1:0]         bit_last;
    logic [3:0]            width_in;

`ifdef UART_TX_CTS_EN
    logic [1:0] cts_sync_q, cts_sync_d;
    assign cts_sync_d = {cts_sync_q[0], cts_n_i};
    // Two-flop synchroniser; resets to "not clear" so nothing starts before the pin settles.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) cts_sync_q <= 2'b11;
        else          cts_sync_q <= cts_sync_d;
    end
    assign cts_ok = ~cts_sync_q[1];
`else
    assign cts_ok = 1'b1;
`endif

    assign full  = (level_q == LW'(FIFO_DEPTH));
    assign empty = (level_q == '0);
    // A write at full is still accepted when the FSM pops in the same cycle.
    assign push  = write_i && !flush_i && (!full || pop);
    assign ovf_d = write_i && !flush_i && full && !pop;

    // Clamp the requested width into the supported range before latching.
    always_comb begin
        width_in = data_width_i;
        if (data_width_i < 4'd5)                   width_in = 4'd5;
        else if (data_width_i > 4'(DATA_MAX_W))    width_in = 4'(DATA_MAX_W);
    end

    // Last tick index of the current bit; STOP stretches it to the latched stop length.
    always_comb begin
        bit_last = CW'(OVS_RATIO - 1);
        if (state_q == S_STOP) begin
            case (stop_q)
                2'b01:   bit_last = CW'(OVS_RATIO * 3 / 2 - 1);
                2'b10:   bit_last = CW'(2 * OVS_RATIO - 1);
                default: bit_last = CW'(OVS_RATIO - 1);
            endcase
        end
    end

    assign last_tick = ov_baud_rt_i && (cnt_q == bit_last);

    // Next-state, counters, frame configuration latch and line value.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        width_d    = width_q;
        par_mode_d = par_mode_q;
        stop_d     = stop_q;
        par_d      = par_q;
        done_d     = 1'b0;
        brk_done_d = 1'b0;
        pop        = 1'b0;

        if (state_q != S_IDLE && ov_baud_rt_i)
            cnt_d = last_tick ? '0 : cnt_q + CW'(1);

        case (state_q)
            S_IDLE: begin
                if (enable_i && !empty && cts_ok) begin
                    state_d    = S_START;
                    pop        = 1'b1;
                    shift_d    = mem_q[rd_ptr_q];
                    width_d    = width_in;
                    par_mode_d = parity_mode_i;
                    stop_d     = stop_bits_i;
                    par_d      = 1'b0;
                    cnt_d      = '0;
                    bit_d      = '0;
                end else if (break_req_i && empty) begin
                    state_d = S_BREAK;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            S_START: if (last_tick) state_d = S_DATA;
            S_DATA: begin
                if (last_tick) begin
                    shift_d = shift_q >> 1;
                    par_d   = par_q ^ shift_q[0];
                    if (bit_q == BW'(width_q) - BW'(1)) begin
                        bit_d   = '0;
                        state_d = par_mode_q[1] ? S_STOP : S_PARITY;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            S_PARITY: if (last_tick) state_d = S_STOP;
            S_STOP: begin
                if (last_tick) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_BREAK: begin
                if (last_tick) begin
                    if (bit_q == BW'(BREAK_BITS - 1)) begin
                        bit_d      = '0;
                        brk_done_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush_i) begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            bit_d      = '0;
            pop        = 1'b0;
            done_d     = 1'b0;
            brk_done_d = 1'b0;
        end

        case (state_q)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_q[0];
            S_PARITY: tx_d = par_mode_q[0] ? ~par_q : par_q;
            S_BREAK:  tx_d = 1'b0;
            default:  tx_d = 1'b1;
        endcase
    end

    // FSM and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            width_q    <= 4'd5;
            par_mode_q <= 2'b10;
            stop_q     <= 2'b00;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
            brk_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            width_q    <= width_d;
            par_mode_q <= par_mode_d;
            stop_q     <= stop_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
            brk_done_q <= brk_done_d;
        end
    end

    // FIFO pointer and level bookkeeping; flush overrides everything.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
    end

    // FIFO control registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage; contents need no reset because level gates every read.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= data_i;
    end

    assign tx_o         = tx_q;
    assign tx_done_o    = done_q;
    assign break_done_o = brk_done_q;
    assign fifo_full_o  = full;
    assign fifo_empty_o = empty;
    assign fifo_level_o = level_q;
    assign overflow_o   = ovf_q;
    assign idle_o       = (state_q == S_IDLE);

endmodule
